// File: rtl/sqrt_share_pkg.sv
// sqrt_share_pkg
//   Shared definitions for the FP16 square-root sharing arbiter:
//   - state_e    : arbiter FSM states (IDLE, RUN, RESP)
//   - QNAN       : canonical quiet NaN returned for invalid or aborted operations
//   - EXP_MAX    : all-ones FP16 exponent (infinity / NaN)
//   - fp16_sign / fp16_exp / fp16_mant : field extractors used by the
//     special-operand classifier (SQRT_SPECIAL_BYPASS_EN builds).
package sqrt_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [4:0]  EXP_MAX = 5'h1F;

  function automatic logic fp16_sign(input logic [15:0] x);
    return x[15];
  endfunction

  function automatic logic [4:0] fp16_exp(input logic [15:0] x);
    return x[14:10];
  endfunction

  function automatic logic [9:0] fp16_mant(input logic [15:0] x);
    return x[9:0];
  endfunction

endpackage

// File: rtl/sqrt_share_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority picker. The search starts at the
//   requester just above last_grant and wraps modulo N; the first set
//   request bit wins.
//   Ports:
//     req        in  [N-1:0]  request vector
//     last_grant in  [IW-1:0] index of the previous winner
//     grant      out [N-1:0]  one-hot winner (all zero when no request)
//     grant_idx  out [IW-1:0] binary winner index (zero when no request)
//     grant_any  out          at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW:0]    win_sum;
  logic           found;

  always_comb begin
    // Rotate the doubled vector so bit k of req_rot is requester
    // (last_grant + 1 + k) mod N; the lowest set bit is then the winner.
    req_dbl = {req, req};
    req_rot = N'(req_dbl >> ({1'b0, last_grant} + 1'b1));
    win_sum = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, last_grant} + (IW+1)'(k + 1);
      end
    end
    // last_grant + 1 + k never exceeds 2N-1, so one wrap suffices.
    if (win_sum >= (IW+1)'(N)) begin
      win_sum = win_sum - (IW+1)'(N);
    end
    grant_idx = win_sum[IW-1:0];
    grant     = found ? (N'(1) << grant_idx) : '0;
    grant_any = found;
  end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter
//   Shares a single approximate FP16 square-root core among NUM_REQ
//   requesters. Round-robin arbitration, one operation in flight; the result
//   is returned with the owner's ID over a valid/ready channel.
//   Optional build macro: SQRT_SPECIAL_BYPASS_EN -- when defined, zero,
//   negative and inf/NaN operands are answered directly from IDLE without
//   using the core.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     req_valid/req_data    per-requester operand (16 bits each)
//     req_ready             one-hot accept strobe, only in IDLE
//     rsp_valid/rsp_ready   result handshake
//     rsp_data/rsp_id/rsp_err  result, owner, timeout-abort flag
//     sq_in/sq_en           operand and enable to the sqrt core
//     sq_out/sq_done        core result and its valid
//     busy                  FSM is not IDLE
module sqrt_share_arbiter
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic [15:0]           sq_in,
  output logic                  sq_en,
  input  logic [15:0]           sq_out,
  input  logic                  sq_done,
  output logic                  busy
);

  // Counter holds the number of completed RUN cycles, so the abort fires on
  // the TIMEOUT-th RUN cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     opnd_q, opnd_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [15:0]        req_word [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [15:0]        pick_opnd;
  logic [NUM_REQ-1:0] ready_int;
  logic               byp_hit;
  logic [15:0]        byp_val;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign req_word[gi] = req_data[16*gi +: 16];
    end
  endgenerate

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  assign pick_opnd = req_word[pick_idx];

`ifdef SQRT_SPECIAL_BYPASS_EN
  // Zero is checked before sign so that -0 returns -0 rather than NaN;
  // a negative inf/NaN falls into the negative branch and returns QNAN.
  always_comb begin
    byp_hit = 1'b0;
    byp_val = pick_opnd;
    if (fp16_exp(pick_opnd) == 5'd0 && fp16_mant(pick_opnd) == 10'd0) begin
      byp_hit = 1'b1;
    end else if (fp16_sign(pick_opnd)) begin
      byp_hit = 1'b1;
      byp_val = QNAN;
    end else if (fp16_exp(pick_opnd) == EXP_MAX) begin
      byp_hit = 1'b1;
    end
  end
`else
  assign byp_hit = 1'b0;
  assign byp_val = pick_opnd;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rsp_id_d   = rsp_id_q;
    opnd_d     = opnd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    ready_int  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ready_int = pick_grant;
          last_d    = pick_idx;
          rsp_id_d  = pick_idx;
          opnd_d    = pick_opnd;
          cnt_d     = '0;
          if (byp_hit) begin
            rsp_data_d = byp_val;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (sq_done) begin
          rsp_data_d = sq_out;
          rsp_err_d  = 1'b0;
          cnt_d      = '0;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = QNAN;
          rsp_err_d  = 1'b1;
          cnt_d      = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      rsp_id_q   <= '0;
      opnd_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_id_q   <= rsp_id_d;
      opnd_q     <= opnd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Accept strobe is masked during reset so nothing is handshaken while the
  // registers are held.
  assign req_ready = rst ? '0 : ready_int;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign sq_in     = opnd_q;
  assign sq_en     = (state_q == RUN);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
module tb_sqrt_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        rsp_ready = 1'b0;
  logic [15:0] sq_in;
  logic        sq_en;
  logic [15:0] sq_out;
  logic        sq_done;
  logic        busy;
  logic        core_on = 1'b1;

  int checks = 0;
  int errors = 0;
  int model_last = NUM_REQ - 1;

  always #5 clk = ~clk;

  // Stub sqrt core: combinational, answers in the same cycle it is enabled.
  function automatic logic [15:0] core_fn(input logic [15:0] x);
    if (x == 16'h4400) return 16'h4016;
    return {x[7:0], x[15:8]} ^ 16'h00A5;
  endfunction

  assign sq_out  = core_fn(sq_in);
  assign sq_done = core_on & sq_en;

  sqrt_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .sq_in     (sq_in),
    .sq_en     (sq_en),
    .sq_out    (sq_out),
    .sq_done   (sq_done),
    .busy      (busy)
  );

  // Reference: round-robin search upward from last winner, wrapping.
  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic is_special(input logic [15:0] x);
`ifdef SQRT_SPECIAL_BYPASS_EN
    return (x[14:0] == 15'd0) || x[15] || (x[14:10] == 5'h1F);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] special_val(input logic [15:0] x);
    if (x[14:0] == 15'd0) return x;
    if (x[15]) return 16'h7E00;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete operation: accept, wait for the response, optional
  // backpressure, handshake, return to idle.
  task automatic run_op(input string tag, input logic [3:0] vmask, input logic [63:0] data,
                        input int hold, input logic core_ok);
    int          w;
    int          cyc;
    int          exp_lat;
    logic [15:0] op;
    logic [15:0] exp_d;
    logic        exp_e;
    logic        sp;
    core_on   = core_ok;
    rsp_ready = 1'b0;
    req_valid = vmask;
    req_data  = data;
    #1;
    w  = pick(vmask, model_last);
    op = data[16*w +: 16];
    sp = is_special(op);
    if (sp) begin
      exp_d = special_val(op); exp_e = 1'b0; exp_lat = 1;
    end else if (core_ok) begin
      exp_d = core_fn(op); exp_e = 1'b0; exp_lat = 2;
    end else begin
      exp_d = 16'h7E00; exp_e = 1'b1; exp_lat = 1 + TIMEOUT;
    end
    chk({tag, ".grant"}, 32'(req_ready), 32'(1) << w);
    chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
    chk({tag, ".idle_en"}, 32'(sq_en), 32'(0));
    model_last = w;
    tick();
    req_valid = vmask & ~(4'b0001 << w);
    #1;
    chk({tag, ".c1_en"}, 32'(sq_en), sp ? 32'(0) : 32'(1));
    chk({tag, ".c1_busy"}, 32'(busy), 32'(1));
    if (!sp) chk({tag, ".sq_in"}, 32'(sq_in), 32'(op));
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      chk({tag, ".run_en"}, 32'(sq_en), 32'(1));
      chk({tag, ".run_rdy"}, 32'(req_ready), 32'(0));
      chk({tag, ".run_busy"}, 32'(busy), 32'(1));
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'(1));
      chk({tag, ".hold_data"}, 32'(rsp_data), 32'(exp_d));
      chk({tag, ".hold_id"}, 32'(rsp_id), 32'(w));
      chk({tag, ".hold_rdy"}, 32'(req_ready), 32'(0));
      chk({tag, ".hold_busy"}, 32'(busy), 32'(1));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(1));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, ".id"}, 32'(rsp_id), 32'(w));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
    chk({tag, ".resp_en"}, 32'(sq_en), 32'(0));
    tick();
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    chk({tag, ".after_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, ".after_busy"}, 32'(busy), 32'(0));
    $display("op %s: req=%0d operand=%h result=%h err=%0d latency=%0d", tag, w, op, exp_d, exp_e, cyc);
  endtask

  initial begin
    int          cur;
    logic [3:0]  mask;
    logic [63:0] data;

    // Reset state, with requests already present.
    #1;
    rst       = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst.rsp_err", 32'(rsp_err), 32'(0));
    chk("rst.rsp_data", 32'(rsp_data), 32'(0));
    chk("rst.rsp_id", 32'(rsp_id), 32'(0));
    chk("rst.sq_en", 32'(sq_en), 32'(0));
    chk("rst.sq_in", 32'(sq_in), 32'(0));
    chk("rst.req_ready", 32'(req_ready), 32'(0));
    tick();
    tick();
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // Single request through the core.
    run_op("single", 4'b0001, {48'h0, 16'h4400}, 0, 1'b1);

    // All requesters held valid with rsp_ready high: one accept every 3 cycles.
    core_on   = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_data  = {16'h4C00, 16'h4800, 16'h4600, 16'h4000};
    cur = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c % 3 == 0) begin
        cur = pick(4'hF, model_last);
        chk("rr.grant", 32'(req_ready), 32'(1) << cur);
        model_last = cur;
        $display("rr: accept cycle %0d requester %0d", c, cur);
      end else begin
        chk("rr.no_grant", 32'(req_ready), 32'(0));
      end
      if (c % 3 == 2) begin
        chk("rr.valid", 32'(rsp_valid), 32'(1));
        chk("rr.id", 32'(rsp_id), 32'(cur));
        chk("rr.data", 32'(rsp_data), 32'(core_fn(req_data[16*cur +: 16])));
      end else begin
        chk("rr.not_valid", 32'(rsp_valid), 32'(0));
      end
      if (c == 14) req_valid = '0;
      tick();
    end
    rsp_ready = 1'b0;
    #1;
    chk("rr.end_busy", 32'(busy), 32'(0));

    // Backpressure with other requesters pending, then the next one wins.
    run_op("bp", 4'b0111, {16'h0, 16'h4A00, 16'h4900, 16'h4500}, 5, 1'b1);
    run_op("bp_next", 4'b0110, {16'h0, 16'h4A00, 16'h4900, 16'h0}, 0, 1'b1);

    // Core never answers: timeout abort.
    run_op("timeout", 4'b1000, {16'h4200, 48'h0}, 2, 1'b0);

    // Asynchronous reset while RUN, then requester 0 has priority again.
    core_on   = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = {16'h0, 16'h4300, 32'h0};
    #1;
    chk("mrst.grant", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    #1;
    chk("mrst.run_en", 32'(sq_en), 32'(1));
    rst = 1'b1;
    #1;
    chk("mrst.sq_en", 32'(sq_en), 32'(0));
    chk("mrst.busy", 32'(busy), 32'(0));
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'(0));
    tick();
    rst = 1'b0;
    model_last = NUM_REQ - 1;
    tick();
    chk("mrst.idle", 32'(busy), 32'(0));
    run_op("post_rst", 4'b1001, {16'h4700, 32'h0, 16'h4100}, 0, 1'b1);

    // Special operands: bypassed when the feature is built in, else via core.
    run_op("neg", 4'b0001, {48'h0, 16'hC400}, 0, 1'b1);
    run_op("zero", 4'b0001, {48'h0, 16'h0000}, 1, 1'b1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      mask = 4'($urandom_range(1, 15));
      data = {$urandom, $urandom};
      run_op("rand", mask, data, int'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
Shares one approximate FP16 square-root core among NUM_REQ requesters, such as k-means distance lanes needing sqrt of summed squares.
- Round-robin arbitration; one operation in flight at a time.
- Drives the core's in/en, captures its out when done, returns the result with the requester ID over a valid/ready response channel.
- Sits between the distance-accumulate lanes and the single sqrt instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)
TIMEOUT, 15, max cycles in RUN waiting for sq_done before error abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_data  in  16*NUM_REQ  FP16 operands; requester i at bits [16i+15:16i]
req_ready  out  NUM_REQ  one-hot accept strobe
rsp_valid  out  1  result valid
rsp_data  out  16  FP16 sqrt result
rsp_id  out  ID_W  requester that owns the result
rsp_err  out  1  result aborted by timeout (rsp_data = 16'h7E00)
rsp_ready  in  1  consumer accepts result
sq_in  out  16  operand to sqrt core
sq_en  out  1  core enable
sq_out  in  16  core result
sq_done  in  1  core result valid
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state) clears all registers:
  - state=IDLE; rsp_valid=0, rsp_err=0, rsp_data=0, rsp_id=0.
  - sq_en=0, sq_in=0; req_ready=0; wait counter=0.
  - last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - An in-flight operation is dropped with no response.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid, winner = first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - req_ready[winner]=1 combinationally this cycle only; handshake completes here.
  - Operand and ID are registered; last_grant <= winner; go to RUN.
  - With no req_valid, remain in IDLE.
- RUN:
  - sq_en=1 and sq_in=operand register, both from registers.
  - Wait counter increments each RUN cycle.
  - On sq_done=1: capture sq_out into rsp_data, rsp_err=0, go to RESP.
  - If counter reaches TIMEOUT without sq_done: rsp_data=16'h7E00, rsp_err=1, go to RESP.
  - Exiting RUN clears the counter. sq_en drops to 0 on leaving RUN.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake go to IDLE; rsp_valid=0 the next cycle.
- Latency with a combinational core (sq_done=sq_en):
  - Accept at cycle 0; RUN at cycle 1; rsp_valid at cycle 2.
  - With rsp_ready held high, a new accept can occur at cycle 3, so peak throughput is 1 op per 3 cycles.
- req_ready is never asserted outside IDLE. Requests stay pending; requesters must hold req_valid/req_data until accepted.
- Fairness: a requester with valid held high waits at most NUM_REQ-1 operations.
- sq_done outside RUN is ignored.
- Widths: all FP16 fields pass through unmodified; no arithmetic on data.

Optional Feature:
Macro SQRT_SPECIAL_BYPASS_EN.
- Defined: in IDLE, an accepted operand is classified:
  - ±zero → result = operand unchanged.
  - sign=1 and nonzero → 16'h7E00.
  - exponent=5'h1F (inf/NaN) → operand unchanged.
  - For these cases, skip RUN and go directly to RESP with rsp_err=0; sq_en is never asserted. Latency: rsp_valid at cycle 1.
- Undefined: every operand goes through RUN and the core.

Decomposition:
- Package sqrt_share_pkg:
  - state enum: IDLE, RUN, RESP.
  - FP16 constants: QNAN=16'h7E00, EXP_MAX=5'h1F.
  - FP16 field-extract functions (sign, exponent, mantissa) used by the bypass classifier.
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, last_grant → one-hot grant + index). Reusable by other shared-unit arbiters.

Test Plan:
- Single request: req_valid=4'b0001, req_data[0]=16'h4400, stub core returns 16'h4016 with sq_done=sq_en → req_ready[0] at cycle 0; rsp_valid at cycle 2 with rsp_data=16'h4016, rsp_id=0, rsp_err=0.
- All four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0 on accept cycles 0,3,6,9,12; each rsp_id matches.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 though req_valid=4'b0110; after rsp_ready, requester 1 is granted.
- Timeout: stub never asserts sq_done, TIMEOUT=15 → rsp_valid after 15 RUN cycles with rsp_err=1, rsp_data=16'h7E00; busy=1 throughout until the handshake.
- Reset mid-RUN: assert rst while in RUN → sq_en, busy, rsp_valid=0 asynchronously; after release, requester 0 wins over requester 3 when both are valid.
- With SQRT_SPECIAL_BYPASS_EN: operand 16'hC400 → rsp_data=16'h7E00 at cycle 1 and sq_en never high; operand 16'h0000 → 16'h0000. Without the macro, both operands reach sq_in.
